load_store_unit: RTL and testbench

Sits between the CPU memory-stage control and the word-addressed data memory (8-bit word address, 32-bit data, combinational read, write on the clock edge). Converts byte-addressed MIPS loads and stores (lb/lbu/lh/lhu/lw/sb/sh/sw) into word accesses. Sub-word loads are lane-extracted and extended. Sub-word stores use a read-modify-write sequence. The CPU is stalled while the sequence runs.

---
 rtl/lsu_pkg.sv | 46 ++++
 rtl/lsu_byte_lane.sv | 69 ++++++
 rtl/load_store_unit.sv | 216 +++++++++++++++++++++
 tb/tb_load_store_unit.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared types and constants for the load/store unit.
//               - lsu_state_t : FSM state encoding (IDLE, RD, WR, DONE)
//               - lsu_size_t  : access-size codes (byte, half, word, reserved)
//               - lane constants and lane_shift() for big-endian lane math
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } lsu_state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } lsu_size_t;

  // Big-endian lanes: byte offset 0 is the most significant byte.
  localparam int         c_LANE_W         = 8;
  localparam int         c_NUM_LANES      = 4;
  localparam logic [4:0] c_HALF_HI_SHIFT  = 5'd16;
  localparam logic [4:0] c_HALF_LO_SHIFT  = 5'd0;
  localparam logic [31:0] c_BYTE_MASK     = 32'h0000_00FF;
  localparam logic [31:0] c_HALF_MASK     = 32'h0000_FFFF;

  // Right-shift that brings byte lane 'off' down to bits [7:0].
  // Shift = 8 * (3 - off); for a 2-bit offset, 3 - off == ~off.
  function automatic logic [4:0] lane_shift(input logic [1:0] off);
    return {~off, 3'b000};
  endfunction

  // Right-shift that brings the halfword selected by off[1] down to [15:0].
  function automatic logic [4:0] half_shift(input logic off_hi);
    return off_hi ? c_HALF_LO_SHIFT : c_HALF_HI_SHIFT;
  endfunction

endpackage : lsu_pkg
`default_nettype wire

// File: rtl/lsu_byte_lane.sv
`default_nettype none
// ============================================================================
// Module      : lsu_byte_lane
// Description : Combinational lane logic for sub-word accesses (big-endian).
//               Extracts and extends a load value from a memory word, and
//               merges store data into a memory word for read-modify-write.
// Ports       :
//   word        in  32  memory word (read data or buffered word)
//   offset      in   2  byte offset inside the word
//   size        in   2  access size (lsu_size_t; reserved treated as word)
//   uns         in   1  1 = zero-extend sub-word loads, 0 = sign-extend
//   store_data  in  32  store data; low byte/half used for sub-word stores
//   load_data   out 32  extended load value
//   merged      out 32  word with the target lane replaced by store data
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  lsu_size_t   size,
  input  logic        uns,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [4:0]  w_bsh;
  logic [4:0]  w_hsh;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_bext;
  logic        w_hext;

  always_comb begin
    w_bsh  = lane_shift(offset);
    w_hsh  = half_shift(offset[1]);
    w_byte = 8'(word >> w_bsh);
    w_half = 16'(word >> w_hsh);
    // Extension bit is the lane's MSB unless zero-extension is requested.
    w_bext = ~uns & w_byte[7];
    w_hext = ~uns & w_half[15];
  end

  always_comb begin
    load_data = word;
    merged    = store_data;
    case (size)
      SZ_BYTE: begin
        load_data = {{24{w_bext}}, w_byte};
        merged    = (word & ~(c_BYTE_MASK << w_bsh)) |
                    ({24'd0, store_data[7:0]} << w_bsh);
      end
      SZ_HALF: begin
        load_data = {{16{w_hext}}, w_half};
        merged    = (word & ~(c_HALF_MASK << w_hsh)) |
                    ({16'd0, store_data[15:0]} << w_hsh);
      end
      default: begin
        // Word and reserved size: pass-through in both directions.
        load_data = word;
        merged    = store_data;
      end
    endcase
  end

endmodule : lsu_byte_lane
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Converts byte-addressed MIPS loads/stores (lb/lbu/lh/lhu/lw/
//               sb/sh/sw) into accesses on a word-addressed data memory with
//               combinational read and clocked write. Sub-word stores are a
//               read-modify-write (RD then WR). The CPU is stalled via
//               LSU_busy while a sequence runs.
// Config      : `define LSU_ALIGN_CHECK_EN to fault misaligned half/word
//               accesses via LSU_misaligned; when undefined, the low address
//               bits are forced to alignment and the access proceeds.
// Ports       :
//   LSU_clk, LSU_rst                 clock, async active-high reset
//   LSU_req, LSU_we, LSU_size,       CPU request (sampled in IDLE)
//   LSU_unsigned, LSU_addr, LSU_wdata
//   LSU_rdata, LSU_busy, LSU_done,   CPU response
//   LSU_misaligned
//   LSU_mem_address, LSU_mem_data_out, data-memory interface
//   LSU_mem_write, LSU_mem_read, LSU_mem_data_in
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_AW = 8,
  parameter int DATA_W = 32
) (
  input  logic              LSU_clk,
  input  logic              LSU_rst,
  input  logic              LSU_req,
  input  logic              LSU_we,
  input  logic [1:0]        LSU_size,
  input  logic              LSU_unsigned,
  input  logic [31:0]       LSU_addr,
  input  logic [DATA_W-1:0] LSU_wdata,
  output logic [DATA_W-1:0] LSU_rdata,
  output logic              LSU_busy,
  output logic              LSU_done,
  output logic              LSU_misaligned,
  output logic [MEM_AW-1:0] LSU_mem_address,
  output logic [DATA_W-1:0] LSU_mem_data_out,
  output logic              LSU_mem_write,
  output logic              LSU_mem_read,
  input  logic [DATA_W-1:0] LSU_mem_data_in
);

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  lsu_state_t        r_state;
  lsu_size_t         r_size;
  logic [1:0]        r_off;
  logic              r_we;
  logic              r_uns;
  logic [31:0]       r_wdata;
  logic [31:0]       r_buf;
  logic [31:0]       r_rdata;
  logic              r_busy;
  logic              r_done;
  logic              r_misaligned;
  logic [MEM_AW-1:0] r_mem_address;
  logic              r_mem_read;
  logic              r_mem_write;

  // --------------------------------------------------------------------------
  // Request decode
  // --------------------------------------------------------------------------
  lsu_size_t   w_size;
  logic [1:0]  w_off;
  logic        w_misaligned;
  logic [31:0] w_lane_word;
  logic [31:0] w_load_data;
  logic [31:0] w_merged;

  // Upper address bits do not reach memory: accesses wrap modulo the
  // memory size.
  logic w_unused_addr_hi;
  assign w_unused_addr_hi = ^LSU_addr[31:MEM_AW+2];

  // Reserved size code behaves exactly like a word access.
  always_comb begin
    w_size = lsu_size_t'(LSU_size);
    if (w_size == SZ_RSVD) begin
      w_size = SZ_WORD;
    end
  end

`ifdef LSU_ALIGN_CHECK_EN
  always_comb begin
    w_off        = LSU_addr[1:0];
    w_misaligned = ((w_size == SZ_HALF) && LSU_addr[0]) ||
                   ((w_size == SZ_WORD) && (LSU_addr[1:0] != 2'b00));
  end
`else
  // Without the check, misaligned accesses are silently rounded down to the
  // natural boundary of their size.
  always_comb begin
    w_off        = LSU_addr[1:0];
    w_misaligned = 1'b0;
    if (w_size == SZ_HALF) begin
      w_off[0] = 1'b0;
    end else if (w_size == SZ_WORD) begin
      w_off = 2'b00;
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Lane logic: in RD the load value comes straight from memory so it can be
  // registered on the same edge; in WR the merge uses the buffered word.
  // --------------------------------------------------------------------------
  assign w_lane_word = (r_state == RD) ? LSU_mem_data_in : r_buf;

  lsu_byte_lane u_lane (
    .word       (w_lane_word),
    .offset     (r_off),
    .size       (r_size),
    .uns        (r_uns),
    .store_data (r_wdata),
    .load_data  (w_load_data),
    .merged     (w_merged)
  );

  // --------------------------------------------------------------------------
  // FSM with registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge LSU_clk or posedge LSU_rst) begin
    if (LSU_rst) begin
      r_state       <= IDLE;
      r_size        <= SZ_BYTE;
      r_off         <= 2'b00;
      r_we          <= 1'b0;
      r_uns         <= 1'b0;
      r_wdata       <= '0;
      r_buf         <= '0;
      r_rdata       <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_misaligned  <= 1'b0;
      r_mem_address <= '0;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
    end else begin
      // Pulses last exactly one cycle.
      r_done       <= 1'b0;
      r_misaligned <= 1'b0;
      case (r_state)
        IDLE: begin
          if (LSU_req) begin
            if (w_misaligned) begin
              r_misaligned <= 1'b1;
            end else begin
              r_size        <= w_size;
              r_off         <= w_off;
              r_we          <= LSU_we;
              r_uns         <= LSU_unsigned;
              r_wdata       <= LSU_wdata;
              r_mem_address <= LSU_addr[MEM_AW+1:2];
              r_busy        <= 1'b1;
              // Only a full-word store can skip the read.
              if (LSU_we && (w_size == SZ_WORD)) begin
                r_state     <= WR;
                r_mem_write <= 1'b1;
              end else begin
                r_state    <= RD;
                r_mem_read <= 1'b1;
              end
            end
          end
        end
        RD: begin
          r_buf      <= LSU_mem_data_in;
          r_mem_read <= 1'b0;
          if (r_we) begin
            r_state     <= WR;
            r_mem_write <= 1'b1;
          end else begin
            r_rdata       <= w_load_data;
            r_state       <= DONE;
            r_busy        <= 1'b0;
            r_done        <= 1'b1;
            r_mem_address <= '0;
          end
        end
        WR: begin
          r_mem_write   <= 1'b0;
          r_mem_address <= '0;
          r_busy        <= 1'b0;
          r_done        <= 1'b1;
          r_state       <= DONE;
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign LSU_rdata        = r_rdata;
  assign LSU_busy         = r_busy;
  assign LSU_done         = r_done;
  assign LSU_misaligned   = r_misaligned;
  assign LSU_mem_address  = r_mem_address;
  assign LSU_mem_read     = r_mem_read;
  assign LSU_mem_write    = r_mem_write;
  // Write data only leaves the unit while the write strobe is up.
  assign LSU_mem_data_out = (r_state == WR) ? w_merged : '0;

endmodule : load_store_unit
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Directed self-checking bench for load_store_unit with a
//               256-word data-memory model (combinational read, clocked
//               write). Expected values are hand-computed constants.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

  logic        LSU_clk = 1'b0;
  logic        LSU_rst;
  logic        LSU_req;
  logic        LSU_we;
  logic [1:0]  LSU_size;
  logic        LSU_unsigned;
  logic [31:0] LSU_addr;
  logic [31:0] LSU_wdata;
  logic [31:0] LSU_rdata;
  logic        LSU_busy;
  logic        LSU_done;
  logic        LSU_misaligned;
  logic [7:0]  LSU_mem_address;
  logic [31:0] LSU_mem_data_out;
  logic        LSU_mem_write;
  logic        LSU_mem_read;
  logic [31:0] LSU_mem_data_in;

  int total = 0;
  int bad   = 0;

  always #5 LSU_clk = ~LSU_clk;

  load_store_unit #(.MEM_AW(8), .DATA_W(32)) dut (
    .LSU_clk          (LSU_clk),
    .LSU_rst          (LSU_rst),
    .LSU_req          (LSU_req),
    .LSU_we           (LSU_we),
    .LSU_size         (LSU_size),
    .LSU_unsigned     (LSU_unsigned),
    .LSU_addr         (LSU_addr),
    .LSU_wdata        (LSU_wdata),
    .LSU_rdata        (LSU_rdata),
    .LSU_busy         (LSU_busy),
    .LSU_done         (LSU_done),
    .LSU_misaligned   (LSU_misaligned),
    .LSU_mem_address  (LSU_mem_address),
    .LSU_mem_data_out (LSU_mem_data_out),
    .LSU_mem_write    (LSU_mem_write),
    .LSU_mem_read     (LSU_mem_read),
    .LSU_mem_data_in  (LSU_mem_data_in)
  );

  // Data memory model with a bench-side preload port.
  logic [31:0] mem [0:255];
  logic        pre_we = 1'b0;
  logic [7:0]  pre_a  = 8'd0;
  logic [31:0] pre_d  = 32'd0;

  always @(posedge LSU_clk) begin
    if (LSU_mem_write) mem[LSU_mem_address] <= LSU_mem_data_out;
    else if (pre_we)   mem[pre_a] <= pre_d;
  end

  assign LSU_mem_data_in = mem[LSU_mem_address];

  task automatic step();
    @(posedge LSU_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    pre_we = 1'b1;
    pre_a  = a;
    pre_d  = d;
    step();
    pre_we = 1'b0;
  endtask

  // Present a request for one cycle; returns just after the acceptance edge.
  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd);
    LSU_we       = we;
    LSU_size     = sz;
    LSU_unsigned = uns;
    LSU_addr     = a;
    LSU_wdata    = wd;
    LSU_req      = 1'b1;
    step();
    LSU_req      = 1'b0;
  endtask

  initial begin
    LSU_rst      = 1'b1;
    LSU_req      = 1'b0;
    LSU_we       = 1'b0;
    LSU_size     = 2'b00;
    LSU_unsigned = 1'b0;
    LSU_addr     = 32'd0;
    LSU_wdata    = 32'd0;

    preload(8'd3, 32'h8081_7F01);
    preload(8'd4, 32'hCAFE_F00D);

    // Reset state
    chk("rst_rdata",   LSU_rdata,              32'h0);
    chk("rst_busy",    {31'd0, LSU_busy},      32'h0);
    chk("rst_done",    {31'd0, LSU_done},      32'h0);
    chk("rst_misal",   {31'd0, LSU_misaligned},32'h0);
    chk("rst_mrd",     {31'd0, LSU_mem_read},  32'h0);
    chk("rst_mwr",     {31'd0, LSU_mem_write}, 32'h0);
    chk("rst_maddr",   {24'd0, LSU_mem_address}, 32'h0);
    chk("rst_mdout",   LSU_mem_data_out,       32'h0);
    LSU_rst = 1'b0;
    step();

    // lb at 0x0D -> lane [23:16] = 0x81, sign-extended
    issue(1'b0, 2'b00, 1'b0, 32'h0000_000D, 32'h0);
    chk("lb_rd_strobe", {31'd0, LSU_mem_read}, 32'h1);
    chk("lb_rd_addr",   {24'd0, LSU_mem_address}, 32'h3);
    chk("lb_rd_busy",   {31'd0, LSU_busy}, 32'h1);
    step();
    chk("lb_done",      {31'd0, LSU_done}, 32'h1);
    chk("lb_rdata",     LSU_rdata, 32'hFFFF_FF81);
    chk("lb_done_busy", {31'd0, LSU_busy}, 32'h0);
    chk("lb_done_mrd",  {31'd0, LSU_mem_read}, 32'h0);
    step();
    chk("lb_idle_done", {31'd0, LSU_done}, 32'h0);

    // lbu at 0x0D
    issue(1'b0, 2'b00, 1'b1, 32'h0000_000D, 32'h0);
    step();
    chk("lbu_done",  {31'd0, LSU_done}, 32'h1);
    chk("lbu_rdata", LSU_rdata, 32'h0000_0081);
    step();

    // lh at 0x0D: faults with the check enabled, else reads half at 0x0C
    issue(1'b0, 2'b01, 1'b0, 32'h0000_000D, 32'h0);
`ifdef LSU_ALIGN_CHECK_EN
    chk("lh_misal",     {31'd0, LSU_misaligned}, 32'h1);
    chk("lh_mis_mrd",   {31'd0, LSU_mem_read}, 32'h0);
    chk("lh_mis_busy",  {31'd0, LSU_busy}, 32'h0);
    chk("lh_mis_rdata", LSU_rdata, 32'h0000_0081);
    step();
    chk("lh_mis_pulse", {31'd0, LSU_misaligned}, 32'h0);
    chk("lh_mis_done",  {31'd0, LSU_done}, 32'h0);
`else
    chk("lh_rd_addr",   {24'd0, LSU_mem_address}, 32'h3);
    chk("lh_misal",     {31'd0, LSU_misaligned}, 32'h0);
    step();
    chk("lh_done",      {31'd0, LSU_done}, 32'h1);
    chk("lh_rdata",     LSU_rdata, 32'hFFFF_8081);
    step();
`endif

    // lhu at 0x40E wraps to 0x00E -> word 3, low half
    issue(1'b0, 2'b01, 1'b1, 32'h0000_040E, 32'h0);
    chk("lhu_rd_addr", {24'd0, LSU_mem_address}, 32'h3);
    step();
    chk("lhu_rdata",   LSU_rdata, 32'h0000_7F01);
    step();

    // sb 0xAB at 0x0E -> lane [15:8]
    issue(1'b1, 2'b00, 1'b0, 32'h0000_000E, 32'h0000_00AB);
    chk("sb_rd_strobe", {31'd0, LSU_mem_read}, 32'h1);
    chk("sb_rd_addr",   {24'd0, LSU_mem_address}, 32'h3);
    chk("sb_rd_nowr",   {31'd0, LSU_mem_write}, 32'h0);
    step();
    chk("sb_wr_strobe", {31'd0, LSU_mem_write}, 32'h1);
    chk("sb_wr_noread", {31'd0, LSU_mem_read}, 32'h0);
    chk("sb_wr_data",   LSU_mem_data_out, 32'h8081_AB01);
    chk("sb_wr_addr",   {24'd0, LSU_mem_address}, 32'h3);
    step();
    chk("sb_done",      {31'd0, LSU_done}, 32'h1);
    chk("sb_done_mwr",  {31'd0, LSU_mem_write}, 32'h0);
    chk("sb_mem3",      mem[3], 32'h8081_AB01);
    chk("sb_rdata_hold", LSU_rdata, 32'h0000_7F01);
    step();

    // sw 0xDEADBEEF at 0x3FC -> word 0xFF, no read phase
    issue(1'b1, 2'b10, 1'b0, 32'h0000_03FC, 32'hDEAD_BEEF);
    chk("sw_wr_strobe", {31'd0, LSU_mem_write}, 32'h1);
    chk("sw_wr_addr",   {24'd0, LSU_mem_address}, 32'hFF);
    chk("sw_noread",    {31'd0, LSU_mem_read}, 32'h0);
    chk("sw_wr_data",   LSU_mem_data_out, 32'hDEAD_BEEF);
    step();
    chk("sw_done",      {31'd0, LSU_done}, 32'h1);
    chk("sw_done_mrd",  {31'd0, LSU_mem_read}, 32'h0);
    chk("sw_done_maddr", {24'd0, LSU_mem_address}, 32'h0);
    chk("sw_memff",     mem[255], 32'hDEAD_BEEF);
    step();

    // sh 0x1234 at 0x10, reset during WR
    issue(1'b1, 2'b01, 1'b0, 32'h0000_0010, 32'h0000_1234);
    chk("sh_rd_addr",  {24'd0, LSU_mem_address}, 32'h4);
    step();
    chk("sh_wr_data",  LSU_mem_data_out, 32'h1234_F00D);
    chk("sh_wr_strobe", {31'd0, LSU_mem_write}, 32'h1);
    #3;
    LSU_rst = 1'b1;
    #1;
    chk("sh_rst_mwr",   {31'd0, LSU_mem_write}, 32'h0);
    chk("sh_rst_busy",  {31'd0, LSU_busy}, 32'h0);
    chk("sh_rst_maddr", {24'd0, LSU_mem_address}, 32'h0);
    chk("sh_rst_mdout", LSU_mem_data_out, 32'h0);
    step();
    chk("sh_rst_mem4",  mem[4], 32'hCAFE_F00D);
    chk("sh_rst_rdata", LSU_rdata, 32'h0);
    chk("sh_rst_done",  {31'd0, LSU_done}, 32'h0);
    LSU_rst = 1'b0;
    step();

    // lw of word 4 after reset: write was aborted
    issue(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0);
    step();
    chk("lw_done",  {31'd0, LSU_done}, 32'h1);
    chk("lw_rdata", LSU_rdata, 32'hCAFE_F00D);
    step();

    // Reserved size code behaves as a word load
    issue(1'b0, 2'b11, 1'b0, 32'h0000_000C, 32'h0);
    chk("rsv_rd_addr", {24'd0, LSU_mem_address}, 32'h3);
    step();
    chk("rsv_rdata", LSU_rdata, 32'h8081_AB01);
    step();
    chk("final_idle_busy", {31'd0, LSU_busy}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_load_store_unit
`default_nettype wire
